// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised serial input, mid-bit sampling, registered
// rx_valid / frame_err pulses and a held output byte.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic        rxMeta_q, rxSync_q;
  logic [15:0] bitCnt_q, bitCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shiftReg_q, shiftReg_d;
  logic [7:0]  data_q, data_d;
  logic        rxValid_q, rxValid_d;
  logic        frameErr_q, frameErr_d;
  logic        halfDone, fullDone;

  // The raw line only ever feeds the first synchroniser flop; it idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= RxD;
      rxSync_q <= rxMeta_q;
    end
  end

  assign halfDone = (bitCnt_q == HALF_LAST);
  assign fullDone = (bitCnt_q == FULL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxSync_q) state_d = START;
      START:     if (halfDone) state_d = rxSync_q ? IDLE : DATA;
      DATA:      if (fullDone && (bitIdx_q == 3'd7)) state_d = STOP;
      STOP:      if (fullDone) state_d = rxSync_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxSync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter restarts on every transition and at each data bit boundary, so it
  // never passes FULL_LAST and cannot wrap.
  always_comb begin
    bitCnt_d   = bitCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    data_d     = data_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;

    if (state_d != state_q) begin
      bitCnt_d = 16'd0;
    end else if ((state_q == START) || (state_q == DATA) || (state_q == STOP)) begin
      bitCnt_d = fullDone ? 16'd0 : bitCnt_q + 16'd1;
    end else begin
      bitCnt_d = 16'd0;
    end

    case (state_q)
      START: begin
        bitIdx_d = 3'd0;
      end
      DATA: begin
        if (fullDone) begin
          shiftReg_d[bitIdx_q] = rxSync_q;
          bitIdx_d             = bitIdx_q + 3'd1;
        end
      end
      STOP: begin
        if (fullDone) begin
          if (rxSync_q) begin
            data_d    = shiftReg_q;
            rxValid_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      default: begin
        bitIdx_d = bitIdx_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt_q   <= 16'd0;
      bitIdx_q   <= 3'd0;
      shiftReg_q <= 8'h00;
      data_q     <= 8'h00;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      data_q     <= data_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    data      = data_q;
    rx_valid  = rxValid_q;
    frame_err = frameErr_q;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomised frames driven into uart_receiver, compared against a
// frame-level model of received bytes, error pulses and latency.
module tb_uart_receiver;

  localparam int CPB     = 16;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks     = 0;
  int errors     = 0;
  int cycle      = 0;
  int validCount = 0;
  int ferrCount  = 0;
  int pulseCycle = -1000;
  int frameStart = 0;
  int expValid   = 0;
  int expFerr    = 0;
  logic [7:0] modelData = 8'h00;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .data      (data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses are sampled just after each rising edge, clear of the bench's negedge driving.
  always @(posedge clk) begin
    #1;
    if (rx_valid || frame_err) begin
      checkOutput("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
      pulseCycle = cycle;
    end
    if (rx_valid) begin
      validCount++;
      rxQ.push_back(data);
    end
    if (frame_err) ferrCount++;
  end

  task automatic idleCycles(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; a low stop bit is left on the line.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    int lat;
    RxD = 1'b0;
    frameStart = cycle + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stopBit;
    repeat (CPB) @(negedge clk);
    if (stopBit) begin
      expValid++;
      expQ.push_back(b);
      modelData = b;
    end else begin
      expFerr++;
    end
    lat = pulseCycle - frameStart;
    checkOutput("latency_window", 32'((lat >= LATENCY - 1) && (lat <= LATENCY + 1)), 32'd1);
  endtask

  task automatic checkFrame();
    checkOutput("valid_count", 32'(validCount), 32'(expValid));
    checkOutput("ferr_count", 32'(ferrCount), 32'(expFerr));
    while ((rxQ.size() > 0) && (expQ.size() > 0))
      checkOutput("rx_byte", 32'(rxQ.pop_front()), 32'(expQ.pop_front()));
    checkOutput("data_held", 32'(data), 32'(modelData));
  endtask

  initial begin
    logic [7:0] b;
    logic       stopBit;

    reset = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h00);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idleCycles(4);

    applyStimulus(8'hA5, 1'b1);
    checkFrame();
    checkOutput("busy_after_good", 32'(busy), 32'd0);

    // Bad stop bit: line stays low, receiver must sit waiting for high.
    applyStimulus(8'h55, 1'b0);
    checkFrame();
    repeat (2 * CPB) @(negedge clk);
    checkOutput("wait_high_busy", 32'(busy), 32'd1);
    checkOutput("wait_high_single_ferr", 32'(ferrCount), 32'(expFerr));
    idleCycles(4);
    checkOutput("wait_high_released", 32'(busy), 32'd0);

    RxD = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("glitch_enters_start", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    idleCycles(2 * CPB);
    checkFrame();
    checkOutput("glitch_back_idle", 32'(busy), 32'd0);

    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    checkFrame();
    idleCycles(CPB);

    RxD = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    expFerr++;
    checkFrame();
    checkOutput("break_busy", 32'(busy), 32'd1);
    idleCycles(4);
    checkOutput("break_released", 32'(busy), 32'd0);
    checkOutput("break_single_ferr", 32'(ferrCount), 32'(expFerr));

    // Abort 0xFF half way through bit 4.
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    modelData = 8'h00;
    checkOutput("midframe_reset_data", 32'(data), 32'h00);
    checkOutput("midframe_reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("midframe_reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idleCycles(3 * CPB);
    checkFrame();
    applyStimulus(8'h81, 1'b1);
    checkFrame();

    for (int n = 0; n < 10; n++) begin
      b       = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 3) != 0);
      applyStimulus(b, stopBit);
      checkFrame();
      if (stopBit) idleCycles($urandom_range(0, CPB));
      else idleCycles(CPB + $urandom_range(0, CPB));
    end

    idleCycles(CPB);
    checkFrame();
    checkOutput("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
